// File: rtl/muldiv_ctrl_pkg.sv
// Shared opcode and state constants for the E-stage multiply/divide sequencer.
// The MDS_* encodings are public so hazard and debug logic can decode busy state.
package muldiv_ctrl_pkg;

  localparam logic [7:0] ALUOP_MULT  = 8'h18;
  localparam logic [7:0] ALUOP_MULTU = 8'h19;
  localparam logic [7:0] ALUOP_DIV   = 8'h1A;
  localparam logic [7:0] ALUOP_DIVU  = 8'h1B;
  localparam logic [7:0] ALUOP_MTHI  = 8'h1C;
  localparam logic [7:0] ALUOP_MTLO  = 8'h1D;
  localparam logic [7:0] ALUOP_MFHI  = 8'h1E;
  localparam logic [7:0] ALUOP_MFLO  = 8'h1F;

  localparam logic [1:0] MDS_IDLE = 2'd0;
  localparam logic [1:0] MDS_MUL  = 2'd1;
  localparam logic [1:0] MDS_DIV  = 2'd2;
  localparam logic [1:0] MDS_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = MDS_IDLE,
    S_MUL  = MDS_MUL,
    S_DIV  = MDS_DIV,
    S_DONE = MDS_DONE
  } md_state_e;

  function automatic logic is_mul_op(input logic [7:0] op);
    return (op == ALUOP_MULT) || (op == ALUOP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// quotient/remainder show the result of the current step, so they are final while done is high.
module div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [W+1:0]  diff;
  logic          ge;

  // Dividend bits shift out of the quotient register's MSB into the partial remainder.
  assign diff      = {1'b0, rem_q, quo_q[W-1]} - {2'b00, dvs_q};
  assign ge        = ~diff[W+1];
  assign quotient  = {quo_q[W-2:0], ge};
  assign remainder = ge ? diff[W-1:0] : {rem_q[W-2:0], quo_q[W-1]};
  assign done      = busy_q & (cnt_q == LAST);

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
    end else if (busy_q) begin
      quo_d = quotient;
      rem_d = remainder;
      cnt_d = cnt_q + CW'(1);
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// E-stage MULT/DIV sequencer owning HI/LO; stalls F/D/E while a multiply or divide is in flight.
// Divide by zero is a no-op; a flush in MUL/DIV abandons the operation with HI/LO untouched.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_e,
  input  logic              flush_e,
  input  logic [7:0]        aluop_e,
  input  logic [DATA_W-1:0] srca_e,
  input  logic [DATA_W-1:0] srcb_e,
  output logic              stall_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  md_state_e           state_q, state_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, op_a_q, op_a_d, op_b_q, op_b_d;
  logic                mul_signed_q, mul_signed_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic                issue, op_signed, start_mul, start_div, start, div_abort, div_done;
  logic [DATA_W-1:0]   abs_a, abs_b, div_quo, div_rem;
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;

  // Gating with rst keeps stall_o low while reset is held, even if valid_e is still up.
  assign issue     = rst & valid_e & ~flush_e & (state_q == S_IDLE);
  assign op_signed = (aluop_e == ALUOP_MULT) | (aluop_e == ALUOP_DIV);
  assign start_mul = issue & is_mul_op(aluop_e);
  assign start_div = issue & is_div_op(aluop_e) & (srcb_e != '0);
  assign start     = start_mul | start_div;
  assign abs_a     = (op_signed & srca_e[DATA_W-1]) ? -srca_e : srca_e;
  assign abs_b     = (op_signed & srcb_e[DATA_W-1]) ? -srcb_e : srcb_e;
  assign div_abort = flush_e & (state_q == S_DIV);

  // A 64x64 product truncated to 64 bits is correct for both signed and unsigned operands.
  assign ext_a = {{DATA_W{mul_signed_q & op_a_q[DATA_W-1]}}, op_a_q};
  assign ext_b = {{DATA_W{mul_signed_q & op_b_q[DATA_W-1]}}, op_b_q};
  assign prod  = ext_a * ext_b;

  div_iter #(.W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start_div),
    .abort     (div_abort),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    mul_signed_d = mul_signed_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_mul) begin
          op_a_d       = srca_e;
          op_b_d       = srcb_e;
          mul_signed_d = op_signed;
          state_d      = S_MUL;
        end else if (start_div) begin
          neg_quo_d = op_signed & (srca_e[DATA_W-1] ^ srcb_e[DATA_W-1]);
          neg_rem_d = op_signed & srca_e[DATA_W-1];
          state_d   = S_DIV;
        end else if (issue && aluop_e == ALUOP_MTHI) begin
          hi_d = srca_e;
        end else if (issue && aluop_e == ALUOP_MTLO) begin
          lo_d = srca_e;
        end
      end
      S_MUL: begin
        if (flush_e) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = prod[2*DATA_W-1:DATA_W];
          lo_d    = prod[DATA_W-1:0];
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        if (flush_e) begin
          state_d = S_IDLE;
        end else if (div_done) begin
          lo_d    = neg_quo_q ? -div_quo : div_quo;
          hi_d    = neg_rem_q ? -div_rem : div_rem;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      mul_signed_q <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      mul_signed_q <= mul_signed_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
    end
  end

  assign stall_o = ~flush_e & (start | (state_q == S_MUL) | (state_q == S_DIV));
  assign busy_o  = (state_q != S_IDLE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, flush/reset corner sequences,
// and random operations checked against an arithmetic HI/LO model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_e = 1'b0;
  logic        flush_e = 1'b0;
  logic [7:0]  aluop_e = 8'h00;
  logic [31:0] srca_e = '0;
  logic [31:0] srcb_e = '0;
  logic        stall_o, busy_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int failures = 0;

  muldiv_ctrl #(.DATA_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_e (valid_e),
    .flush_e (flush_e),
    .aluop_e (aluop_e),
    .srca_e  (srca_e),
    .srcb_e  (srcb_e),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction in E, holds it while stalled, then lets it advance one edge.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_stalls);
    int stalls;
    valid_e = 1'b1;
    flush_e = 1'b0;
    aluop_e = op;
    srca_e  = a;
    srcb_e  = b;
    stalls  = 0;
    #1;
    while (stall_o && stalls < 100) begin
      stalls++;
      step();
      #1;
    end
    chk({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
    chk({tag, " busy_last"}, {31'd0, busy_o}, {31'd0, exp_stalls != 0});
    if (exp_stalls != 0) begin
      chk({tag, " hi_in_done"}, hi_o, exp_hi);
      chk({tag, " lo_in_done"}, lo_o, exp_lo);
    end
    step();
    chk({tag, " hi"}, hi_o, exp_hi);
    chk({tag, " lo"}, lo_o, exp_lo);
    $display("txn %s op=%02h a=%h b=%h stalls=%0d hi=%h lo=%h", tag, op, a, b, stalls, hi_o, lo_o);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] specials [4];
    specials[0] = 32'h80000000;
    specials[1] = 32'hFFFFFFFF;
    specials[2] = 32'h00000001;
    specials[3] = 32'h7FFFFFFF;
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 20));
      2:       return 32'hFFFFFFFF - 32'($urandom_range(0, 20));
      default: return specials[$urandom_range(0, 3)];
    endcase
  endfunction

  initial begin
    logic [7:0]  ops [6];
    logic [31:0] m_hi, m_lo, ra, rb;
    logic [63:0] p;
    longint      sa, sb, q, r;
    int          exp_st, lost;
    logic [7:0]  rop;

    vecs[0]  = '{ALUOP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 2};
    vecs[1]  = '{ALUOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
    vecs[2]  = '{ALUOP_MULTU, 32'd5,        32'd7,        32'h00000000, 32'h00000023, 2};
    vecs[3]  = '{ALUOP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[4]  = '{ALUOP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
    vecs[5]  = '{ALUOP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[6]  = '{ALUOP_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'h80000000, 0};
    vecs[7]  = '{ALUOP_MTLO,  32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0};
    vecs[8]  = '{ALUOP_DIV,   32'd55,       32'd0,        32'h00001234, 32'h00005678, 0};
    vecs[9]  = '{ALUOP_MTHI,  32'hCAFEBABE, 32'd0,        32'hCAFEBABE, 32'h00005678, 0};
    vecs[10] = '{ALUOP_MFHI,  32'h11111111, 32'd0,        32'hCAFEBABE, 32'h00005678, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", hi_o, 32'h0);
    chk("reset lo", lo_o, 32'h0);
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    chk("reset busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b1;
    step();

    // Directed table, applied back to back with no bubbles
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].stalls);
    valid_e = 1'b0;
    step();

    // MTLO under flush must not write LO
    valid_e = 1'b1; flush_e = 1'b1; aluop_e = ALUOP_MTLO; srca_e = 32'hDEADBEEF;
    #1;
    chk("mtlo_flush stall", {31'd0, stall_o}, 32'd0);
    step();
    flush_e = 1'b0; valid_e = 1'b0;
    #1;
    chk("mtlo_flush lo", lo_o, 32'h00005678);
    $display("txn mtlo_flush lo=%h", lo_o);

    // DIVU flushed at iteration 10
    valid_e = 1'b1; aluop_e = ALUOP_DIVU; srca_e = 32'd100; srcb_e = 32'd7;
    #1;
    chk("divflush detect stall", {31'd0, stall_o}, 32'd1);
    lost = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      #1;
      if (!stall_o) lost++;
    end
    chk("divflush stall held", 32'(lost), 32'd0);
    flush_e = 1'b1;
    #1;
    chk("divflush stall drop", {31'd0, stall_o}, 32'd0);
    step();
    flush_e = 1'b0; valid_e = 1'b0;
    #1;
    chk("divflush busy", {31'd0, busy_o}, 32'd0);
    chk("divflush hi", hi_o, 32'hCAFEBABE);
    chk("divflush lo", lo_o, 32'h00005678);
    $display("txn div_flush hi=%h lo=%h busy=%0d", hi_o, lo_o, busy_o);
    run_op("div_after_abort", ALUOP_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, 33);

    // Asynchronous reset in the middle of a multiply
    aluop_e = ALUOP_MULT; srca_e = 32'd7; srcb_e = 32'd9;
    #1;
    chk("rstmul detect stall", {31'd0, stall_o}, 32'd1);
    step();
    #1;
    rst = 1'b0;
    #1;
    chk("rstmul hi", hi_o, 32'h0);
    chk("rstmul lo", lo_o, 32'h0);
    chk("rstmul stall", {31'd0, stall_o}, 32'd0);
    chk("rstmul busy", {31'd0, busy_o}, 32'd0);
    step();
    rst = 1'b1; valid_e = 1'b0;
    step();
    chk("rstmul after busy", {31'd0, busy_o}, 32'd0);
    chk("rstmul after hi", hi_o, 32'h0);
    $display("txn reset_mid_mul hi=%h lo=%h", hi_o, lo_o);

    // Random operations against an arithmetic model
    ops[0] = ALUOP_MULT; ops[1] = ALUOP_MULTU; ops[2] = ALUOP_DIV;
    ops[3] = ALUOP_DIVU; ops[4] = ALUOP_MTHI;  ops[5] = ALUOP_MTLO;
    m_hi = 32'h0;
    m_lo = 32'h0;
    for (int n = 0; n < 40; n++) begin
      rop = ops[$urandom_range(0, 5)];
      ra  = rnd_operand();
      rb  = rnd_operand();
      if (is_div_op(rop) && $urandom_range(0, 7) == 0) rb = 32'h0;
      sa = $signed(ra);
      sb = $signed(rb);
      exp_st = 0;
      case (rop)
        ALUOP_MULT: begin
          p = sa * sb;
          m_hi = p[63:32]; m_lo = p[31:0]; exp_st = 2;
        end
        ALUOP_MULTU: begin
          p = {32'd0, ra} * {32'd0, rb};
          m_hi = p[63:32]; m_lo = p[31:0]; exp_st = 2;
        end
        ALUOP_DIV: if (rb != 0) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0]; exp_st = 33;
        end
        ALUOP_DIVU: if (rb != 0) begin
          m_lo = ra / rb; m_hi = ra % rb; exp_st = 33;
        end
        ALUOP_MTHI: m_hi = ra;
        default:    m_lo = ra;
      endcase
      run_op($sformatf("rnd%0d", n), rop, ra, rb, m_hi, m_lo, exp_st);
    end
    valid_e = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Execute-stage sequencer for the multi-cycle MULT/MULTU/DIV/DIVU operations that the ALU-op decode routes to the E stage.
- Owns the architectural HI/LO registers and services MTHI/MTLO writes.
- Runs an iterative divider and a registered multiplier, and raises a pipeline stall while either is busy.
- Sits beside the ALU in E; its stall output feeds the hazard unit, and hi_o/lo_o feed the MFHI/MFLO result mux.

Parameters:
- DATA_W, 32, operand and HI/LO width. Only 32 is supported; the divider iteration count equals DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_e  in  1  E stage holds a real instruction (not a bubble).
- flush_e  in  1  E-stage instruction is cancelled (exception or branch flush).
- aluop_e  in  8  decoded ALU op from the shared ALUOP_* constants.
- srca_e  in  DATA_W  rs operand, after forwarding.
- srcb_e  in  DATA_W  rt operand, after forwarding.
- stall_o  out  1  hold the F/D/E stages this cycle.
- busy_o  out  1  FSM is not in IDLE (debug and performance counter).
- hi_o  out  DATA_W  current HI.
- lo_o  out  DATA_W  current LO.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hi_o=0, lo_o=0, divider counter=0. Consequently stall_o=0 and busy_o=0.
- FSM states: IDLE, MUL, DIV, DONE.
- Start condition: valid_e & ~flush_e & state==IDLE & aluop_e in {MULT, MULTU, DIV, DIVU}.
  - DIV/DIVU with srcb_e==0 does not start. There is no stall and HI/LO are unchanged; divide by zero is defined as a no-op.
- stall_o = ~flush_e & (start | state==MUL | state==DIV). This is combinational, so the detect cycle is already stalled.
- IDLE, MULT/MULTU: latch both operands and the signedness flag, then go to MUL.
- MUL: register the 64-bit product (signed or unsigned). Write HI=prod[63:32] and LO=prod[31:0], then go to DONE.
- IDLE, DIV/DIVU: latch |srca| and |srcb| (abs only for DIV), sign_q = sa^sb, sign_r = sa. Pulse start to the divider, then go to DIV.
- DIV: one quotient bit per cycle for 32 cycles.
  - On the divider's done: LO = sign_q ? -q : q and HI = sign_r ? -r : r. Then go to DONE.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (two's-complement wrap, no trap).
- DONE: stall_o=0 so the held instruction advances; go to IDLE unconditionally. The instruction still sitting in E during DONE never retriggers a start.
- Cycles resident in E: MULT 3 (2 stalled), DIV 34 (33 stalled).
- MTHI/MTLO: in IDLE with valid_e & ~flush_e, HI (or LO) <= srca_e at the clock edge, with no stall. In any other state the pipeline is stalled and they cannot reach E.
- MFHI/MFLO: read hi_o/lo_o directly. Both registers are updated on entry to DONE, so a dependent MFHI in the next instruction sees the new value.
- flush_e while in MUL or DIV: return to IDLE at the next edge, abort the divider, HI/LO unchanged. stall_o drops in the same cycle.
- flush_e in DONE or IDLE: no start and no HI/LO write.
- Reset mid-operation: immediate return to the reset state; the partial result is discarded.

Decomposition:
- The ALUOP_* codes come from the shared defines header; this block adds no new opcodes.
- FSM state encodings (2-bit localparams S_IDLE/S_MUL/S_DIV/S_DONE) belong in the shared header as MDS_* constants, so the hazard unit and debug logic can decode busy state.
- One sub-module, div_iter: unsigned radix-2 restoring divider.
  - Ports: clk, rst, start, abort, dividend, divisor, quotient, remainder, done.
  - 32-iteration counter; done pulses for one cycle.

Test Plan:
- MULT srca=0xFFFFFFFE, srcb=3 -> stall_o high 2 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall_o=0 in DONE.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Back-to-back MULTU restarts only after DONE.
- DIV -7 (0xFFFFFFF9) / 2 -> 33 stall cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=0x0000000E, HI=0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIV x/0 with HI=0x1234, LO=0x5678 preset -> no stall; HI/LO remain 0x1234/0x5678.
- MTHI 0xCAFEBABE then MFHI next cycle -> hi_o=0xCAFEBABE. MTLO with flush_e=1 -> lo_o unchanged.
- DIVU 100/7 with flush_e at iteration 10 -> stall_o drops that cycle, IDLE next edge, HI/LO unchanged. rst=0 mid-MUL -> hi_o=lo_o=0, stall_o=0 asynchronously.
